button_pulser_multi: RTL and testbench

- N-channel button front end: per channel, 2-FF synchronizer, counter debouncer, and a pulse FSM emitting one-cycle press pulses.
- Optional per-channel auto-repeat: while a button is held, pulses repeat at a programmable delay and rate.
- Sits between raw active-low board buttons and game/control FSMs that consume single-cycle events (menu step, segment move).

---
 rtl/button_pulser_multi.sv | 126 ++++++++++++
 tb/tb_button_pulser_multi.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulser_multi.sv
// N-channel button front end: 2-FF synchronizer, counter debouncer and a
// press/auto-repeat pulse FSM per channel, all channels independent.
module button_pulser_multi #(
  parameter int unsigned N             = 4,
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [N-1:0] Bin,
  input  logic [N-1:0] RepEn,
  output logic [N-1:0] Bout,
  output logic [N-1:0] Pressed
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    HOLD  = 3'd2,
    RPT   = 3'd3,
    RWAIT = 3'd4,
    WAIT  = 3'd5
  } state_t;

  for (genvar g = 0; g < int'(N); g++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             pressed;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] tmr;
    logic             bout;
    state_t           state;

    // Synchronizer and debouncer; pressed is the active-high debounced level.
    always_ff @(posedge Clk) begin
      if (!Rst) begin
        s1      <= 1'b1;
        s2      <= 1'b1;
        pressed <= 1'b0;
        dcnt    <= '0;
      end else begin
        s1 <= Bin[g];
        s2 <= s1;
        if (s2 == ~pressed) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          pressed <= ~s2;
          dcnt    <= '0;
        end else begin
          dcnt <= dcnt + CNT_W'(1);
        end
      end
    end

    // Pulse FSM; bout is set on the same edge that enters FIRST or RPT.
    always_ff @(posedge Clk) begin
      if (!Rst) begin
        state <= IDLE;
        tmr   <= '0;
        bout  <= 1'b0;
      end else begin
        bout <= 1'b0;
        case (state)
          IDLE: begin
            if (pressed) begin
              state <= FIRST;
              bout  <= 1'b1;
            end
          end
          FIRST: begin
            if (RepEn[g]) begin
              state <= HOLD;
              tmr   <= '0;
            end else begin
              state <= WAIT;
            end
          end
          HOLD: begin
            if (!pressed) begin
              state <= IDLE;
            end else if (tmr == HOLD_LAST) begin
              state <= RPT;
              bout  <= 1'b1;
            end else begin
              tmr <= tmr + CNT_W'(1);
            end
          end
          RPT: begin
            state <= RWAIT;
            tmr   <= '0;
          end
          RWAIT: begin
            if (!pressed) begin
              state <= IDLE;
            end else if (!RepEn[g]) begin
              state <= WAIT;
            end else if (tmr == REP_LAST) begin
              state <= RPT;
              bout  <= 1'b1;
            end else begin
              tmr <= tmr + CNT_W'(1);
            end
          end
          WAIT: begin
            if (!pressed) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end

    assign Bout[g]    = bout;
    assign Pressed[g] = pressed;
  end

endmodule

// File: tb/tb_button_pulser_multi.sv
// Bench for button_pulser_multi: vector table, hand-timed pulse sequences and
// randomized traffic checked every cycle against a behavioural model.
module tb_button_pulser_multi;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 16;
  localparam int REP  = 8;
  localparam int NV   = 49;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [N-1:0] Bin;
  logic [N-1:0] RepEn;
  logic [N-1:0] Bout;
  logic [N-1:0] Pressed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  button_pulser_multi #(
    .N(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(16)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Bin(Bin), .RepEn(RepEn), .Bout(Bout), .Pressed(Pressed)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model: debounce as "last DEB delayed samples all disagree",
  // pulses as arithmetic on the age since the first pulse.
  logic [N-1:0] hist [DEB+1];
  logic [N-1:0] m_pr;
  logic [N-1:0] m_bout;
  bit           active [N];
  bit           rep    [N];
  int           age    [N];

  always @(posedge Clk) begin
    logic [N-1:0] nb;
    logic [N-1:0] np;
    if (!Rst) begin
      for (int k = 0; k <= DEB; k++) hist[k] = '1;
      m_pr   = '0;
      m_bout = '0;
      for (int c = 0; c < N; c++) begin
        active[c] = 1'b0;
        rep[c]    = 1'b0;
        age[c]    = 0;
      end
    end else begin
      nb = '0;
      np = m_pr;
      for (int c = 0; c < N; c++) begin
        if (!active[c]) begin
          if (m_pr[c]) begin
            active[c] = 1'b1;
            age[c]    = 0;
            nb[c]     = 1'b1;
          end
        end else begin
          int old_age;
          old_age = age[c];
          age[c]  = age[c] + 1;
          if (old_age == 0) rep[c] = RepEn[c];
          if (!m_bout[c] && !m_pr[c]) begin
            active[c] = 1'b0;
          end else begin
            if (!m_bout[c] && old_age > HOLD && !RepEn[c]) rep[c] = 1'b0;
            nb[c] = rep[c] && age[c] >= HOLD + 1 && ((age[c] - HOLD - 1) % (REP + 1)) == 0;
          end
        end
        begin
          bit all;
          all = 1'b1;
          for (int k = 1; k <= DEB; k++) if (hist[k][c] != m_pr[c]) all = 1'b0;
          if (all) np[c] = ~m_pr[c];
        end
      end
      m_bout = nb;
      m_pr   = np;
      for (int k = DEB; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = Bin;
    end
  end

  // Cycle-by-cycle comparison against the model, plus a pulse log.
  int plog[$];
  always @(negedge Clk) begin
    if (chk_en) begin
      n_checks++;
      if (Bout !== m_bout) begin
        n_fail++;
        $display("FAIL model Bout cyc %0d: got %b expected %b", cyc, Bout, m_bout);
      end
      n_checks++;
      if (Pressed !== m_pr) begin
        n_fail++;
        $display("FAIL model Pressed cyc %0d: got %b expected %b", cyc, Pressed, m_pr);
      end
      for (int c = 0; c < N; c++) if (Bout[c] === 1'b1) plog.push_back(c * 1000000 + cyc);
    end
  end

  int expq[$];

  task automatic check_pulses(input string name, input int ch);
    int got[$];
    foreach (plog[i]) if (plog[i] / 1000000 == ch) got.push_back(plog[i] % 1000000);
    n_checks++;
    if (got.size() != expq.size()) begin
      n_fail++;
      $display("FAIL %s ch%0d pulse count: got %0d expected %0d", name, ch, got.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] != expq[i]) begin
        n_fail++;
        $display("FAIL %s ch%0d pulse %0d edge: got %0d expected %0d", name, ch, i, got[i], expq[i]);
      end
    end
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] bin;
    logic [N-1:0] rep;
    logic [N-1:0] eb;
    logic [N-1:0] ep;
  } vec_t;

  vec_t tbl [NV];
  int   cd  [N];

  initial begin
    int p, p2, r, e;
    // Vector k is applied before edge k-1 (relative to first low sample of ch0).
    for (int k = 0; k < NV; k++) begin
      tbl[k].rst    = (k != 0);
      tbl[k].bin    = '1;
      tbl[k].bin[0] = !(k >= 1 && k <= 40);
      tbl[k].bin[1] = !(k inside {10, 12, 13, 15, 16, 17});
      tbl[k].rep    = '0;
      tbl[k].eb     = (k == 7) ? 4'b0001 : 4'b0000;
      tbl[k].ep     = (k >= 6 && k <= 45) ? 4'b0001 : 4'b0000;
    end

    Rst = 1'b0; Bin = '1; RepEn = '0;
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      Rst = tbl[i].rst; Bin = tbl[i].bin; RepEn = tbl[i].rep;
      @(negedge Clk);
      n_checks++;
      if (Bout !== tbl[i].eb) begin
        n_fail++;
        $display("FAIL vec %0d Bout: got %b expected %b", i, Bout, tbl[i].eb);
      end
      n_checks++;
      if (Pressed !== tbl[i].ep) begin
        n_fail++;
        $display("FAIL vec %0d Pressed: got %b expected %b", i, Pressed, tbl[i].ep);
      end
    end
    Rst = 1'b1; Bin = '1; RepEn = '0;
    repeat (10) @(negedge Clk);

    // Held press with auto-repeat.
    plog.delete();
    RepEn[2] = 1'b1; Bin[2] = 1'b0; p = cyc + 1;
    repeat (60) @(negedge Clk);
    Bin[2] = 1'b1;
    repeat (30) @(negedge Clk);
    RepEn[2] = 1'b0;
    e = p + DEB + 2;
    expq = {e, e + 17, e + 26, e + 35, e + 44, e + 53};
    check_pulses("repeat", 2);

    // Release inside the hold window, then re-press.
    plog.delete();
    RepEn[3] = 1'b1; Bin[3] = 1'b0; p = cyc + 1;
    repeat (16) @(negedge Clk);
    Bin[3] = 1'b1;
    repeat (20) @(negedge Clk);
    Bin[3] = 1'b0; p2 = cyc + 1;
    repeat (10) @(negedge Clk);
    Bin[3] = 1'b1;
    repeat (20) @(negedge Clk);
    RepEn[3] = 1'b0;
    expq = {p + 6, p2 + 6};
    check_pulses("early_release", 3);

    // Simultaneous press, channel 1 bounces.
    plog.delete();
    Bin[0] = 1'b0; Bin[1] = 1'b0; p = cyc + 1;
    @(negedge Clk);
    Bin[1] = 1'b1;
    @(negedge Clk);
    Bin[1] = 1'b0;
    repeat (30) @(negedge Clk);
    Bin[1:0] = 2'b11;
    repeat (20) @(negedge Clk);
    expq = {p + 6};
    check_pulses("simul", 0);
    expq = {p + 8};
    check_pulses("simul_bounce", 1);

    // Reset during RWAIT with the button held.
    plog.delete();
    RepEn[2] = 1'b1; Bin[2] = 1'b0; p = cyc + 1;
    repeat (26) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (Bout !== 4'b0000 || Pressed !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_rwait: got Bout %b Pressed %b expected 0000 0000", Bout, Pressed);
    end
    Rst = 1'b1; r = cyc + 1;
    repeat (10) @(negedge Clk);
    Bin[2] = 1'b1;
    repeat (25) @(negedge Clk);
    RepEn[2] = 1'b0;
    expq = {p + 6, p + 23, r + 6};
    check_pulses("reset_rwait", 2);

    // Randomized traffic with bounces, RepEn changes and occasional reset.
    for (int c = 0; c < N; c++) cd[c] = $urandom_range(0, 20);
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (cd[c] == 0) begin
          Bin[c] = ~Bin[c];
          cd[c]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 60));
        end else begin
          cd[c] = cd[c] - 1;
        end
        if ($urandom_range(0, 15) == 0) RepEn[c] = ~RepEn[c];
      end
      Rst = ($urandom_range(0, 399) != 0);
      @(negedge Clk);
    end
    Rst = 1'b1; Bin = '1; RepEn = '0;
    repeat (20) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
